// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and constants for the parametrised register file.
`default_nettype none

package regfile_pkg;

  localparam int RF_WIDTH    = 32;
  localparam int RF_DEPTH    = 32;
  localparam int RF_NUM_RD   = 2;
  localparam int RF_ZERO_IDX = 0;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_read_port.sv
// regfile_read_port: one read port with range/zero/bypass/array priority and
// an optional output register.
`default_nettype none

module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int REG_READ = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [AW-1:0]               rd_addr,
  output logic [WIDTH-1:0]            rd_data
);

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] raw;

  // Explicit compare-and-select keeps the mux well defined for non-power-of-two depths.
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == AW'(i)) sel = regs[i];
    end
  end

  always_comb begin
    raw = sel;
    if ({1'b0, rd_addr} >= DEPTH_LIM)
      raw = '0;
    else if (ZERO_REG != 0 && rd_addr == AW'(RF_ZERO_IDX))
      raw = '0;
    else if (BYPASS != 0 && wr_en && wr_addr == rd_addr)
      raw = wr_data;
  end

  if (REG_READ != 0) begin : g_reg_read
    always_ff @(posedge clock) begin
      if (reset) rd_data <= '0;
      else       rd_data <= raw;
    end
  end else begin : g_comb_read
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;
    assign rd_data = raw;
  end

endmodule : regfile_read_port

`default_nettype wire

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file, NUM_RD read ports, one write port.
`default_nettype none

module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int REG_READ = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data
);

  if (NUM_RD < 1 || NUM_RD > 4 || DEPTH < 2) begin : g_bad_param
    $error("regfile_param: illegal NUM_RD or DEPTH");
  end

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic                        wr_ok;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_LIM) &&
                 !(ZERO_REG != 0 && wr_addr == AW'(RF_ZERO_IDX));

  always_ff @(posedge clock) begin
    if (reset) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok && wr_addr == AW'(i)) regs[i] <= wr_data;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS),
      .REG_READ(REG_READ)
    ) u_port (
      .clock  (clock),
      .reset  (reset),
      .regs   (regs),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_addr(rd_addr[k*AW +: AW]),
      .rd_data(rd_data[k*WIDTH +: WIDTH])
    );
  end

endmodule : regfile_param

`default_nettype wire

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed checks of five regfile_param configurations sharing one stimulus.
`default_nettype none

module tb_regfile_param;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_def, rd_alt, rd_reg, rd_regb, rd_odd;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // default: zero reg, bypass, combinational read
  regfile_param u_def (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_def));

  regfile_param #(.ZERO_REG(0), .BYPASS(0)) u_alt (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_alt));

  regfile_param #(.REG_READ(1), .BYPASS(0)) u_reg (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_reg));

  regfile_param #(.REG_READ(1), .BYPASS(1)) u_regb (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_regb));

  regfile_param #(.DEPTH(20)) u_odd (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_odd));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (rd_reg !== 64'h0) begin
      errors++;
      $display("FAIL reset_regread: got %h expected %h", rd_reg, 64'h0);
    end
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      checks++;
      if (rd_def !== 64'h0 || rd_alt !== 64'h0) begin
        errors++;
        $display("FAIL reset_read a=%0d: got def=%h alt=%h expected 0", a, rd_def, rd_alt);
      end
    end
  endtask

  task automatic test_write_readback();
    wr_en = 1'b1; wr_addr = 5'd5;  wr_data = 32'hDEADBEEF;
    tick();
    wr_addr = 5'd31; wr_data = 32'h12345678;
    tick();
    wr_en = 1'b0;
    rd_addr = {5'd31, 5'd5};
    #1;
    checks++;
    if (rd_def !== {32'h12345678, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL readback_def: got %h expected %h", rd_def, {32'h12345678, 32'hDEADBEEF});
    end
    checks++;
    if (rd_alt !== {32'h12345678, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL readback_alt: got %h expected %h", rd_alt, {32'h12345678, 32'hDEADBEEF});
    end
    checks++;
    if (rd_odd !== {32'h0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL readback_odd: got %h expected %h", rd_odd, {32'h0, 32'hDEADBEEF});
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    tick();
    wr_en = 1'b0;
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_def[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg_on: got %h expected %h", rd_def[31:0], 32'h0);
    end
    checks++;
    if (rd_alt[63:32] !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL zero_reg_off: got %h expected %h", rd_alt[63:32], 32'hFFFFFFFF);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    rd_addr = {5'd7, 5'd7};
    #1;
    checks++;
    if (rd_def[31:0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass_on: got %h expected %h", rd_def[31:0], 32'hA5A5A5A5);
    end
    checks++;
    if (rd_alt[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL bypass_off_same: got %h expected %h", rd_alt[31:0], 32'h0);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd_alt[31:0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL bypass_off_next: got %h expected %h", rd_alt[31:0], 32'hA5A5A5A5);
    end
    checks++;
    if (rd_reg[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL regread_prewrite: got %h expected %h", rd_reg[31:0], 32'h0);
    end
    checks++;
    if (rd_regb[31:0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL regread_bypass: got %h expected %h", rd_regb[31:0], 32'hA5A5A5A5);
    end
    tick();
    checks++;
    if (rd_reg[63:32] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL regread_after: got %h expected %h", rd_reg[63:32], 32'hA5A5A5A5);
    end
  endtask

  task automatic test_reg_latency();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    rd_addr = {5'd0, 5'd0};
    tick();
    wr_en = 1'b0;
    rd_addr = {5'd0, 5'd3};
    #1;
    checks++;
    if (rd_reg[31:0] !== 32'h0 || rd_def[31:0] !== 32'h55) begin
      errors++;
      $display("FAIL latency_before: got reg=%h def=%h expected reg=0 def=55", rd_reg[31:0], rd_def[31:0]);
    end
    tick();
    checks++;
    if (rd_reg[31:0] !== 32'h55) begin
      errors++;
      $display("FAIL latency_after: got %h expected %h", rd_reg[31:0], 32'h55);
    end
    // reset beats a same-cycle write, but the bypass still forwards it
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1234;
    rd_addr = {5'd9, 5'd3};
    #1;
    checks++;
    if (rd_def[63:32] !== 32'h1234) begin
      errors++;
      $display("FAIL reset_bypass: got %h expected %h", rd_def[63:32], 32'h1234);
    end
    tick();
    reset = 1'b0;
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd_reg !== 64'h0) begin
      errors++;
      $display("FAIL latency_reset: got %h expected %h", rd_reg, 64'h0);
    end
    checks++;
    if (rd_def !== 64'h0) begin
      errors++;
      $display("FAIL reset_cleared: got %h expected %h", rd_def, 64'h0);
    end
    tick();
    checks++;
    if (rd_reg !== 64'h0) begin
      errors++;
      $display("FAIL reset_r3_reg: got %h expected %h", rd_reg, 64'h0);
    end
  endtask

  task automatic test_odd_depth();
    wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'h99;
    rd_addr = {5'd19, 5'd25};
    #1;
    checks++;
    if (rd_odd !== 64'h0) begin
      errors++;
      $display("FAIL odd_oor_bypass: got %h expected %h", rd_odd, 64'h0);
    end
    tick();
    wr_addr = 5'd19; wr_data = 32'h77;
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd_odd !== {32'h77, 32'h0}) begin
      errors++;
      $display("FAIL odd_read: got %h expected %h", rd_odd, {32'h77, 32'h0});
    end
    checks++;
    if (rd_def !== {32'h77, 32'h99}) begin
      errors++;
      $display("FAIL deep_read: got %h expected %h", rd_def, {32'h77, 32'h99});
    end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_zero_reg();
    test_bypass();
    test_reg_latency();
    test_odd_depth();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_param

`default_nettype wire
